// File: rtl/inner_memory_handler_if.sv
// Shared request encodings and the pipeline-to-handler memory bundle.
package inner_memory_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } memrw_t;

    // Encodings follow funct3 so bit 2 marks unsigned loads and bits [1:0] give the size.
    typedef enum logic [2:0] {
        RW_B  = 3'b000,
        RW_H  = 3'b001,
        RW_W  = 3'b010,
        RW_BU = 3'b100,
        RW_HU = 3'b101
    } rw_type_t;

endpackage

interface inner_memory_if;
    import inner_memory_pkg::*;

    memrw_t      MemRW;
    rw_type_t    RWType;
    logic [31:0] addr_out;
    logic [31:0] data_out;
    logic [31:0] data_in;

    modport handler (
        input  MemRW,
        input  RWType,
        input  addr_out,
        input  data_out,
        output data_in
    );

    modport pipeline (
        output MemRW,
        output RWType,
        output addr_out,
        output data_out,
        input  data_in
    );
endinterface

// File: rtl/inner_memory_handler.sv
// Memory-stage handler: turns pipeline load/store requests into single word-wide
// bus transfers, formats sub-word data, and stalls the pipeline until done.
module inner_memory_handler
    import inner_memory_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    inner_memory_if.handler        mem,
    output logic                   stall,
    output logic                   misalign,
    output logic                   bus_err,
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [31:0]            bus_addr,
    output logic [31:0]            bus_wdata,
    output logic [3:0]             bus_wstrb,
    input  logic                   bus_ready,
    input  logic [31:0]            bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t      stateQ, stateD;
    logic [7:0]  cntQ, cntD;
    logic [31:0] dataInQ, dataInD;
    logic [31:0] addrQ, wdataQ;
    logic [3:0]  wstrbQ;
    logic        weQ;
    logic [1:0]  laneQ, sizeQ;
    logic        unsQ;

    logic        reqValid, reqWrite, isByte, isHalf, misaligned, accept;
    logic [31:0] fmtWdata;
    logic [3:0]  fmtWstrb;
    logic [7:0]  rdByte;
    logic [15:0] rdHalf;
    logic [31:0] rdFmt;
    logic        stallC, misalignC, busErrC;

    assign reqValid = (mem.MemRW != MEM_NONE);
    assign reqWrite = (mem.MemRW == MEM_WRITE);
    assign isByte   = (mem.RWType[1:0] == 2'b00);
    assign isHalf   = (mem.RWType[1:0] == 2'b01);

    // Halfwords need an even address; everything that is neither byte nor half is a word.
    always_comb begin
        misaligned = 1'b0;
        if (isHalf) begin
            misaligned = mem.addr_out[0];
        end else if (!isByte) begin
            misaligned = (mem.addr_out[1:0] != 2'b00);
        end
    end

    // Replicate store data across lanes and enable only the addressed bytes.
    always_comb begin
        fmtWdata = '0;
        fmtWstrb = '0;
        if (reqWrite) begin
            if (isByte) begin
                fmtWdata = {4{mem.data_out[7:0]}};
                fmtWstrb = 4'b0001 << mem.addr_out[1:0];
            end else if (isHalf) begin
                fmtWdata = {2{mem.data_out[15:0]}};
                fmtWstrb = mem.addr_out[1] ? 4'b1100 : 4'b0011;
            end else begin
                fmtWdata = mem.data_out;
                fmtWstrb = 4'b1111;
            end
        end
    end

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    always_comb begin
        rdByte = bus_rdata[7:0];
        case (laneQ)
            2'b00:   rdByte = bus_rdata[7:0];
            2'b01:   rdByte = bus_rdata[15:8];
            2'b10:   rdByte = bus_rdata[23:16];
            default: rdByte = bus_rdata[31:24];
        endcase
        rdHalf = laneQ[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (sizeQ)
            2'b00:   rdFmt = {{24{~unsQ & rdByte[7]}}, rdByte};
            2'b01:   rdFmt = {{16{~unsQ & rdHalf[15]}}, rdHalf};
            default: rdFmt = bus_rdata;
        endcase
    end

    // Next-state, stall/pulse outputs and result update for the IDLE/WAIT/DONE sequence.
    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        dataInD   = dataInQ;
        accept    = 1'b0;
        stallC    = 1'b0;
        misalignC = 1'b0;
        busErrC   = 1'b0;
        case (stateQ)
            ST_IDLE: begin
                if (reqValid) begin
                    if (misaligned) begin
                        misalignC = 1'b1;
                        dataInD   = '0;
                    end else begin
                        stallC = 1'b1;
                        accept = 1'b1;
                        cntD   = '0;
                        stateD = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stallC = 1'b1;
                if (bus_ready) begin
                    if (!weQ) begin
                        dataInD = rdFmt;
                    end
                    stateD = ST_DONE;
                end else if (cntQ == 8'(TIMEOUT - 1)) begin
                    busErrC = 1'b1;
                    dataInD = '0;
                    stateD  = ST_DONE;
                end else begin
                    cntD = cntQ + 8'd1;
                end
            end
            ST_DONE: begin
                stateD = ST_IDLE;
            end
            default: begin
                stateD = ST_IDLE;
            end
        endcase
    end

    // State, timeout counter and the registered load result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ  <= ST_IDLE;
            cntQ    <= '0;
            dataInQ <= '0;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            dataInQ <= dataInD;
        end
    end

    // Bus fields and lane/type info are captured once on acceptance and held through WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrQ  <= '0;
            weQ    <= 1'b0;
            wdataQ <= '0;
            wstrbQ <= '0;
            laneQ  <= '0;
            sizeQ  <= '0;
            unsQ   <= 1'b0;
        end else if (accept) begin
            addrQ  <= {mem.addr_out[31:2], 2'b00};
            weQ    <= reqWrite;
            wdataQ <= fmtWdata;
            wstrbQ <= fmtWstrb;
            laneQ  <= mem.addr_out[1:0];
            sizeQ  <= mem.RWType[1:0];
            unsQ   <= mem.RWType[2];
        end
    end

    // Combinational outputs are forced low while reset is held so an abandoned request cannot stall.
    assign stall       = stallC & ~rst;
    assign misalign    = misalignC & ~rst;
    assign bus_err     = busErrC & ~rst;
    assign bus_req     = (stateQ == ST_WAIT);
    assign bus_we      = weQ;
    assign bus_addr    = addrQ;
    assign bus_wdata   = wdataQ;
    assign bus_wstrb   = wstrbQ;
    assign mem.data_in = dataInQ;

endmodule

// File: tb/tb_inner_memory_handler.sv
// Scoreboard bench for inner_memory_handler: stimulus pushes expected transactions,
// a negedge monitor checks bus fields, stall length, errors and results as they appear.
module tb_inner_memory_handler;
    import inner_memory_pkg::*;

    typedef struct {
        logic        misal;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] dataIn;
        logic        err;
        int          stallCycles;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall, misalign, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;

    inner_memory_if memIf();

    inner_memory_handler #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (memIf),
        .stall     (stall),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wstrb (bus_wstrb),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    int   assertCount = 0;
    int   failCount   = 0;
    exp_t expQ[$];

    int          respDelay  = 0;
    bit          respEnable = 0;
    logic [31:0] respData   = '0;
    int          respCnt    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Bus slave model: raises bus_ready respDelay cycles into the transfer, or never when disabled.
    always @(posedge clk) begin
        #1;
        if (bus_req) begin
            bus_ready = respEnable && (respCnt == respDelay);
            bus_rdata = respData;
            respCnt++;
        end else begin
            bus_ready = 1'b0;
            respCnt   = 0;
        end
    end

    int   monStall  = 0;
    int   monErr    = 0;
    bit   prevStall = 0;
    bit   pendZero  = 0;
    exp_t monE;

    // Monitor: checks bus fields every request cycle and the full result when stall falls.
    always @(negedge clk) begin
        if (rst) begin
            monStall  = 0;
            monErr    = 0;
            prevStall = 0;
            pendZero  = 0;
        end else begin
            if (pendZero) begin
                checkOutput("misalign data_in", memIf.data_in, 32'h0);
                pendZero = 0;
            end
            if (misalign) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected misalign", 32'h1, 32'h0);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("misalign expected", 32'h1, {31'h0, monE.misal});
                    checkOutput("misalign stall", {31'h0, stall}, 32'h0);
                    checkOutput("misalign bus_req", {31'h0, bus_req}, 32'h0);
                    pendZero = 1;
                end
            end
            if (bus_req && expQ.size() > 0) begin
                checkOutput("bus_addr", bus_addr, expQ[0].addr);
                checkOutput("bus_we", {31'h0, bus_we}, {31'h0, expQ[0].we});
                checkOutput("bus_wstrb", {28'h0, bus_wstrb}, {28'h0, expQ[0].wstrb});
                if (expQ[0].we) begin
                    checkOutput("bus_wdata", bus_wdata, expQ[0].wdata);
                end
            end
            if (bus_err) monErr++;
            if (stall) begin
                monStall++;
            end else if (prevStall) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected completion", 32'h1, 32'h0);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("data_in", memIf.data_in, monE.dataIn);
                    checkOutput("bus_err pulses", monErr, {31'h0, monE.err});
                    checkOutput("stall cycles", monStall, monE.stallCycles);
                    checkOutput("bus_req dropped", {31'h0, bus_req}, 32'h0);
                end
                monStall = 0;
                monErr   = 0;
            end
            prevStall = stall;
        end
    end

    // Issues one request, queues its expectation, and holds it until the handler releases stall.
    task automatic applyStimulus(input memrw_t rw, input rw_type_t t, input logic [31:0] addr,
                                 input logic [31:0] dout, input int delay, input bit en,
                                 input logic [31:0] rdata, input logic [31:0] expWdata,
                                 input logic [3:0] expStrb, input logic [31:0] expData,
                                 input bit expErr, input int expStall, input bit expMis);
        exp_t e;
        bit   done;
        e.misal       = expMis;
        e.addr        = {addr[31:2], 2'b00};
        e.we          = (rw == MEM_WRITE);
        e.wdata       = expWdata;
        e.wstrb       = expStrb;
        e.dataIn      = expData;
        e.err         = expErr;
        e.stallCycles = expStall;
        expQ.push_back(e);
        respDelay  = delay;
        respEnable = en;
        respData   = rdata;
        memIf.MemRW    = rw;
        memIf.RWType   = t;
        memIf.addr_out = addr;
        memIf.data_out = dout;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1;
        end
        if (!done) checkOutput("stall release bound", 32'h1, 32'h0);
        @(posedge clk);
        #1;
        memIf.MemRW = MEM_NONE;
    endtask

    initial begin
        rst            = 1'b1;
        bus_ready      = 1'b0;
        bus_rdata      = '0;
        memIf.MemRW    = MEM_NONE;
        memIf.RWType   = RW_W;
        memIf.addr_out = '0;
        memIf.data_out = '0;
        @(negedge clk);
        checkOutput("reset stall", {31'h0, stall}, 32'h0);
        checkOutput("reset misalign", {31'h0, misalign}, 32'h0);
        checkOutput("reset bus_err", {31'h0, bus_err}, 32'h0);
        checkOutput("reset bus_req", {31'h0, bus_req}, 32'h0);
        checkOutput("reset bus_we", {31'h0, bus_we}, 32'h0);
        checkOutput("reset bus_addr", bus_addr, 32'h0);
        checkOutput("reset bus_wdata", bus_wdata, 32'h0);
        checkOutput("reset bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
        checkOutput("reset data_in", memIf.data_in, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // rw, type, addr, data_out, delay, respEn, rdata, expWdata, expStrb, expData, expErr, expStall, expMis
        applyStimulus(MEM_READ,  RW_W,  32'h100, 32'h0,        0,  1, 32'hDEADBEEF, 32'h0,        4'b0000, 32'hDEADBEEF, 0, 2,  0);
        applyStimulus(MEM_WRITE, RW_B,  32'h203, 32'h000000A5, 0,  1, 32'h0,        32'hA5A5A5A5, 4'b1000, 32'hDEADBEEF, 0, 2,  0);
        applyStimulus(MEM_READ,  RW_B,  32'h302, 32'h0,        0,  1, 32'h12F45678, 32'h0,        4'b0000, 32'hFFFFFFF4, 0, 2,  0);
        applyStimulus(MEM_READ,  RW_BU, 32'h302, 32'h0,        0,  1, 32'h12F45678, 32'h0,        4'b0000, 32'h000000F4, 0, 2,  0);
        applyStimulus(MEM_READ,  RW_HU, 32'h302, 32'h0,        0,  1, 32'h12F45678, 32'h0,        4'b0000, 32'h000012F4, 0, 2,  0);
        applyStimulus(MEM_READ,  RW_H,  32'h300, 32'h0,        0,  1, 32'h12F48001, 32'h0,        4'b0000, 32'hFFFF8001, 0, 2,  0);
        applyStimulus(MEM_READ,  RW_B,  32'h301, 32'h0,        0,  1, 32'h12F45678, 32'h0,        4'b0000, 32'h00000056, 0, 2,  0);
        applyStimulus(MEM_WRITE, RW_H,  32'h202, 32'h1234BEEF, 2,  1, 32'h0,        32'hBEEFBEEF, 4'b1100, 32'h00000056, 0, 4,  0);
        applyStimulus(MEM_WRITE, RW_BU, 32'h201, 32'h0000003C, 0,  1, 32'h0,        32'h3C3C3C3C, 4'b0010, 32'h00000056, 0, 2,  0);
        applyStimulus(MEM_WRITE, RW_W,  32'h400, 32'hCAFEF00D, 3,  1, 32'h0,        32'hCAFEF00D, 4'b1111, 32'h00000056, 0, 5,  0);
        applyStimulus(MEM_READ,  RW_W,  32'h101, 32'h0,        0,  1, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 0,  1);
        applyStimulus(MEM_READ,  RW_W,  32'h104, 32'h0,        15, 1, 32'h11223344, 32'h0,        4'b0000, 32'h11223344, 0, 17, 0);
        applyStimulus(MEM_WRITE, RW_H,  32'h201, 32'h0,        0,  1, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 0,  1);
        applyStimulus(MEM_READ,  RW_W,  32'h108, 32'h0,        0,  1, 32'h55667788, 32'h0,        4'b0000, 32'h55667788, 0, 2,  0);
        applyStimulus(MEM_WRITE, RW_W,  32'h40C, 32'h00000001, 0,  0, 32'h0,        32'h00000001, 4'b1111, 32'h0,        1, 17, 0);

        // Abandon a read mid-WAIT with reset; no expectation is queued for it.
        respEnable     = 0;
        memIf.MemRW    = MEM_READ;
        memIf.RWType   = RW_W;
        memIf.addr_out = 32'h500;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("pre-reset bus_req", {31'h0, bus_req}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("mid-wait reset bus_req", {31'h0, bus_req}, 32'h0);
        checkOutput("mid-wait reset stall", {31'h0, stall}, 32'h0);
        checkOutput("mid-wait reset data_in", memIf.data_in, 32'h0);
        memIf.MemRW = MEM_NONE;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(MEM_READ,  RW_W,  32'h504, 32'h0,        0,  1, 32'h0BADF00D, 32'h0,        4'b0000, 32'h0BADF00D, 0, 2,  0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
